s_16bit_unfold: RTL and testbench

Streaming inverse of the 16-bit-to-8-bit XOR fold used on the a/b datapaths. Folded bytes aa/bb arrive with their known low halves; the block reconstructs the high halves as `hi = fold ^ lo`. It emits full 16-bit words a/b through a 2-entry output buffer with valid/ready handshakes. It sits downstream of the fold stage, on the receive/unpack side.

---
 rtl/s_16bit_unfold.sv | 172 +++++++++++++++++
 tb/tb_s_16bit_unfold.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/s_16bit_unfold.sv
// s_16bit_unfold: streaming inverse of the 16->8 bit XOR fold.
// Rebuilds {fold ^ lo, lo} for the a and b paths and presents the words
// through a small registered output buffer with valid/ready handshakes.
// Optional build macro: UNFOLD_SIG_EN adds an 8-bit running pop signature.
module s_16bit_unfold #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       aa,
  input  logic [7:0]       bb,
  input  logic [7:0]       a_lo,
  input  logic [7:0]       b_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      a,
  output logic [15:0]      b,
`ifdef UNFOLD_SIG_EN
  output logic [7:0]       sig,
`endif
  output logic [CNT_W-1:0] word_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // High half recovered from the fold: no carries, plain bitwise XOR.
  function automatic logic [7:0] unfold_hi(input logic [7:0] fold, input logic [7:0] lo);
    return fold ^ lo;
  endfunction

  // Re-fold of a 16-bit word back to its 8-bit XOR signature.
  function automatic logic [7:0] fold16(input logic [15:0] w);
    return w[15:8] ^ w[7:0];
  endfunction

  logic [15:0]      mem_a_r [DEPTH];
  logic [15:0]      mem_b_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [15:0]      a_r;
  logic [15:0]      b_r;
  logic [CNT_W-1:0] word_cnt_r;

  logic             accept_s;
  logic             pop_s;
  logic             bypass_s;
  logic [15:0]      in_a_s;
  logic [15:0]      in_b_s;
  logic [OCC_W-1:0] occ_next_s;
  logic [PTR_W-1:0] rd_next_s;
  logic [15:0]      head_a_next_s;
  logic [15:0]      head_b_next_s;

  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;
  assign in_a_s   = {unfold_hi(aa, a_lo), a_lo};
  assign in_b_s   = {unfold_hi(bb, b_lo), b_lo};

  // Next occupancy, read pointer and the word that becomes the head next cycle.
  always_comb begin
    occ_next_s    = occ_r;
    rd_next_s     = rd_ptr_r;
    bypass_s      = 1'b0;
    head_a_next_s = a_r;
    head_b_next_s = b_r;
    case ({accept_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_W'(1);
      2'b01:   occ_next_s = occ_r - OCC_W'(1);
      default: occ_next_s = occ_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    // The incoming word lands on the next read slot only if the buffer drains
    // to nothing this cycle; the memory write is not visible yet, so bypass it.
    if (accept_s && ((occ_r == OCC_W'(0)) || ((occ_r == OCC_W'(1)) && pop_s))) begin
      bypass_s = 1'b1;
    end else begin
      bypass_s = 1'b0;
    end
    if (occ_next_s == OCC_W'(0)) begin
      head_a_next_s = a_r;              // empty: keep the last popped word
      head_b_next_s = b_r;
    end else if (bypass_s) begin
      head_a_next_s = in_a_s;
      head_b_next_s = in_b_s;
    end else begin
      head_a_next_s = mem_a_r[rd_next_s];
      head_b_next_s = mem_b_r[rd_next_s];
    end
  end

  // Buffer storage and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_r[i] <= 16'h0000;
        mem_b_r[i] <= 16'h0000;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (accept_s) begin
      mem_a_r[wr_ptr_r] <= in_a_s;
      mem_b_r[wr_ptr_r] <= in_b_s;
      wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer, occupancy, handshake flags and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      occ_r       <= {OCC_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
    end else begin
      rd_ptr_r    <= rd_next_s;
      occ_r       <= occ_next_s;
      out_valid_r <= (occ_next_s != OCC_W'(0));
      in_ready_r  <= (occ_next_s != OCC_W'(DEPTH));
      a_r         <= head_a_next_s;
      b_r         <= head_b_next_s;
    end
  end

  // Count of accepted words, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

`ifdef UNFOLD_SIG_EN
  logic [7:0] sig_r;

  // Running signature of every popped word, comparable to the transmit fold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= 8'h00;
    end else if (pop_s) begin
      sig_r <= sig_r ^ fold16(a_r) ^ fold16(b_r);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign a         = a_r;
  assign b         = b_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_s_16bit_unfold.sv
// Directed self-checking bench for s_16bit_unfold (DEPTH=2, CNT_W=16).
module tb_s_16bit_unfold;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  aa, bb, a_lo, b_lo;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic [15:0] word_cnt;
`ifdef UNFOLD_SIG_EN
  logic [7:0]  sig;
`endif

  int total = 0;
  int bad   = 0;

  s_16bit_unfold #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aa        (aa),
    .bb        (bb),
    .a_lo      (a_lo),
    .b_lo      (b_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
`ifdef UNFOLD_SIG_EN
    .sig       (sig),
`endif
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] f_a, input logic [7:0] l_a,
                       input logic [7:0] f_b, input logic [7:0] l_b);
    in_valid = v;
    aa = f_a; a_lo = l_a; bb = f_b; b_lo = l_b;
  endtask

  logic [7:0] ka, kl;

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a", {16'd0, a}, 32'h0);
    chk("rst_b", {16'd0, b}, 32'h0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single word
    out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'h0F, 8'h00, 8'h5A);
    tick();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_a", {16'd0, a}, 32'hF00F);
    chk("single_b", {16'd0, b}, 32'h5A5A);
    chk("single_cnt", {16'd0, word_cnt}, 32'd1);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("single_empty", {31'd0, out_valid}, 32'd0);
    chk("single_hold_a", {16'd0, a}, 32'hF00F);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 8'h44, 8'h55);
    tick();
    chk("bp_w1_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'hA0, 8'h0B, 8'hC3, 8'h3C);
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a1", {16'd0, a}, 32'h3322);
    drive(1'b1, 8'h77, 8'h77, 8'h00, 8'hF0);
    tick();
    chk("bp_ignored_cnt", {16'd0, word_cnt}, 32'd3);
    chk("bp_hold_a2", {16'd0, a}, 32'h3322);
    chk("bp_hold_b2", {16'd0, b}, 32'h1155);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_a", {16'd0, a}, 32'hAB0B);
    chk("bp_pop1_b", {16'd0, b}, 32'hFF3C);
    chk("bp_pop1_cnt", {16'd0, word_cnt}, 32'd3);
    chk("bp_pop1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_w3_a", {16'd0, a}, 32'h0077);
    chk("bp_w3_b", {16'd0, b}, 32'hF0F0);
    chk("bp_w3_cnt", {16'd0, word_cnt}, 32'd4);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_drain_hold", {16'd0, a}, 32'h0077);

    // streaming, no bubbles
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h80 ^ 8'(i), 8'(i), 8'(i), 8'h3C);
      tick();
      chk("str_valid", {31'd0, out_valid}, 32'd1);
      chk("str_ready", {31'd0, in_ready}, 32'd1);
      chk("str_a", {16'd0, a}, {16'd0, 8'h80, 8'(i)});
      chk("str_b", {16'd0, b}, {16'd0, 8'(i) ^ 8'h3C, 8'h3C});
    end
    chk("str_cnt", {16'd0, word_cnt}, 32'd14);

    // reset with two words buffered
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
    tick();
    tick();
    chk("mr_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_a", {16'd0, a}, 32'h0);
    chk("mr_b", {16'd0, b}, 32'h0);
    chk("mr_cnt", {16'd0, word_cnt}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 8'hC0, 8'h0C, 8'h5A, 8'hA5);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_new_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_new_a", {16'd0, a}, 32'hCC0C);
    chk("mr_new_b", {16'd0, b}, 32'hFFA5);
    chk("mr_new_cnt", {16'd0, word_cnt}, 32'd1);

    // counter wrap: 65535 further accepts bring the count back to 0
    ka = 8'h00; kl = 8'h00;
    for (int k = 0; k < 65535; k++) begin
      ka = 8'(k);
      kl = 8'(k >> 8);
      drive(1'b1, ka, kl, kl, ka);
      tick();
    end
    chk("wrap_cnt", {16'd0, word_cnt}, 32'd0);
    chk("wrap_a", {16'd0, a}, {16'd0, ka ^ kl, kl});
    chk("wrap_b", {16'd0, b}, {16'd0, kl ^ ka, ka});
    drive(1'b1, 8'h0F, 8'hF0, 8'h33, 8'h33);
    tick();
    chk("wrap_cnt1", {16'd0, word_cnt}, 32'd1);
    chk("wrap_next_a", {16'd0, a}, 32'hFFF0);
    chk("wrap_next_b", {16'd0, b}, 32'h0033);

`ifdef UNFOLD_SIG_EN
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("sig_rst", {24'd0, sig}, 32'h00);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h12, 8'hAB, 8'h34, 8'hCD);
    tick();
    drive(1'b1, 8'hFF, 8'h11, 8'h00, 8'h22);
    tick();
    chk("sig_first", {24'd0, sig}, 32'h26);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("sig_second", {24'd0, sig}, 32'hD9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
